memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/common_types_pkg.sv | 20 ++
 rtl/cpu_ram_if.sv | 23 ++
 rtl/memory_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/common_types_pkg.sv
// Shared enums for the instruction/data memory arbiter.
package common_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

    // Reset value of last_grant: the port that should NOT win the first tie.
    function automatic grant_t reset_last_grant(input bit data_first);
        return data_first ? INSTR : DATA;
    endfunction

endpackage

// File: rtl/cpu_ram_if.sv
// CPU-side instruction and data port bundle seen by the memory arbiter.
interface cpu_ram_if;
    logic        iren;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dren;
    logic [3:0]  dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    modport ram (
        input  iren, iaddr, dren, dwen, daddr, dstore,
        output iload, iwait, dload, dwait
    );

    modport cpu (
        output iren, iaddr, dren, dwen, daddr, dstore,
        input  iload, iwait, dload, dwait
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between an instruction
// and a data port; each access completes on the RAM's ready pulse.
module memory_arbiter
    import common_types_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        nrst,
    cpu_ram_if.ram      cpu,
    output logic        ram_ren,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready
);

    arb_state_t  state_q, state_d;
    grant_t      last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ren_q, ren_d;
    logic [3:0]  wen_q, wen_d;
    logic [31:0] iload_q;
    logic [31:0] dload_q;

    logic ireq;
    logic dreq;
    logic grant_data;
    logic icomplete;
    logic dcomplete;
    logic dread_done;

    assign ireq = cpu.iren;
    assign dreq = cpu.dren | (|cpu.dwen);

    // Next-state and capture values; a tie goes to whichever port lost last time.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ren_d        = ren_q;
        wen_d        = wen_q;
        grant_data   = 1'b0;

        case (state_q)
            IDLE: begin
                ren_d = 1'b0;
                wen_d = 4'd0;
                if (ireq || dreq) begin
                    grant_data = dreq && (!ireq || (last_grant_q == INSTR));
                    if (grant_data) begin
                        state_d      = DACC;
                        last_grant_d = DATA;
                        addr_d       = cpu.daddr;
                        wdata_d      = cpu.dstore;
                        ren_d        = cpu.dren;
                        wen_d        = cpu.dwen;
                    end else begin
                        state_d      = IACC;
                        last_grant_d = INSTR;
                        addr_d       = cpu.iaddr;
                        wdata_d      = 32'd0;
                        ren_d        = 1'b1;
                        wen_d        = 4'd0;
                    end
                end
            end
            IACC, DACC: begin
                if (ram_ready) begin
                    state_d = IDLE;
                    ren_d   = 1'b0;
                    wen_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                ren_d   = 1'b0;
                wen_d   = 4'd0;
            end
        endcase
    end

    // A completion only counts if the requester still asks for what was captured.
    assign icomplete  = nrst && (state_q == IACC) && ram_ready && (cpu.iaddr == addr_q);
    assign dcomplete  = nrst && (state_q == DACC) && ram_ready &&
                        (cpu.daddr == addr_q) && (cpu.dwen == wen_q);
    assign dread_done = dcomplete && (wen_q == 4'd0);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= IDLE;
            last_grant_q <= reset_last_grant(DATA_FIRST);
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            ren_q        <= 1'b0;
            wen_q        <= 4'd0;
            iload_q      <= 32'd0;
            dload_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ren_q        <= ren_d;
            wen_q        <= wen_d;
            if (icomplete) begin
                iload_q <= ram_rdata;
            end
            if (dread_done) begin
                dload_q <= ram_rdata;
            end
        end
    end

    always_comb begin
        cpu.iwait = !icomplete;
        cpu.dwait = !dcomplete;
        cpu.iload = icomplete ? ram_rdata : iload_q;
        cpu.dload = dread_done ? ram_rdata : dload_q;
    end

    assign ram_ren   = ren_q;
    assign ram_wen   = wen_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule
